// File: rtl/adc_seq.sv
// adc_seq: conversion sequencer and result collector for the SAR ADC macro.
// Generates registered INIT/SAMP/COMP/UPDATE strobes. Collects comparator
// decisions MSB-first into a result word. Delivers the word over valid/ready.
// Optional feature: define ADC_SEQ_CONT_EN to honour cfg_cont. When it is
// defined, the sequencer restarts back-to-back without start.
module adc_seq #(
    parameter int MAX_BITS = 16,
    parameter int SAMP_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [SAMP_W-1:0]   cfg_samp_len,
    input  logic [4:0]          cfg_ncomp,
    input  logic                cfg_cont,
    input  logic                comp_out,
    output logic                seq_init,
    output logic                seq_samp,
    output logic                seq_comp,
    output logic                seq_update,
    output logic                busy,
    output logic [MAX_BITS-1:0] result,
    output logic                result_valid,
    input  logic                result_ready,
    output logic                overrun
);

    localparam int CNT_W = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;

`ifdef ADC_SEQ_CONT_EN
    localparam logic CONT_EN = 1'b1;
`else
    localparam logic CONT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        SAMP,
        COMP,
        UPDATE
    } state_t;

    state_t state, next_state;

    logic [SAMP_W-1:0]   samp_len_q;
    logic [SAMP_W-1:0]   samp_cnt;
    logic [SAMP_W-1:0]   samp_eff;
    logic [CNT_W-1:0]    nm1_q;
    logic [CNT_W-1:0]    nm1_eff;
    logic [CNT_W-1:0]    bit_cnt;
    logic [MAX_BITS-1:0] shreg;
    logic                cont_req;
    logic                last_bit;
    logic                samp_done;
    logic                word_done;
    logic                launch;
    logic                out_free;

    assign cont_req  = CONT_EN & cfg_cont;
    assign last_bit  = (bit_cnt == '0);
    assign samp_done = (samp_cnt == '0);
    assign word_done = (state == UPDATE) && last_bit;
    // INIT is only entered from IDLE on start or from a continuous restart,
    // so this is exactly the configuration latch point.
    assign launch    = (next_state == INIT);
    assign out_free  = !result_valid || result_ready;

    // Clamp the sampling length and comparison count of the incoming config
    always_comb begin
        samp_eff = (cfg_samp_len == '0) ? SAMP_W'(1) : cfg_samp_len;
        if (cfg_ncomp == 5'd0 || int'(cfg_ncomp) > MAX_BITS) begin
            nm1_eff = CNT_W'(MAX_BITS - 1);
        end else begin
            nm1_eff = CNT_W'(int'(cfg_ncomp) - 1);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic for the conversion phases
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = INIT;
            INIT:    next_state = SAMP;
            SAMP:    if (samp_done) next_state = COMP;
            COMP:    next_state = UPDATE;
            UPDATE: begin
                if (!last_bit) begin
                    next_state = COMP;
                end else if (cont_req) begin
                    next_state = INIT;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Config latch, phase counters and decision shift register
    always_ff @(posedge clk) begin
        if (rst) begin
            samp_len_q <= SAMP_W'(1);
            nm1_q      <= '0;
            samp_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
        end else begin
            if (launch) begin
                samp_len_q <= samp_eff;
                nm1_q      <= nm1_eff;
            end
            case (state)
                INIT: begin
                    shreg    <= '0;
                    samp_cnt <= samp_len_q - SAMP_W'(1);
                end
                SAMP: begin
                    if (samp_done) begin
                        bit_cnt <= nm1_q;
                    end else begin
                        samp_cnt <= samp_cnt - SAMP_W'(1);
                    end
                end
                COMP: shreg[bit_cnt] <= comp_out;
                UPDATE: begin
                    if (!last_bit) begin
                        bit_cnt <= bit_cnt - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered strobes, busy flag and result handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            seq_init     <= 1'b0;
            seq_samp     <= 1'b0;
            seq_comp     <= 1'b0;
            seq_update   <= 1'b0;
            busy         <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            seq_init   <= (next_state == INIT);
            seq_samp   <= (next_state == SAMP);
            seq_comp   <= (next_state == COMP);
            seq_update <= (next_state == UPDATE);
            busy       <= (next_state != IDLE);
            overrun    <= 1'b0;
            if (word_done && out_free) begin
                result       <= shreg;
                result_valid <= 1'b1;
            end else if (word_done) begin
                overrun <= 1'b1;
            end else if (result_valid && result_ready) begin
                result_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adc_seq.sv
// tb_adc_seq: self-checking bench for adc_seq. It applies a table of
// conversions and runs hand-written multi-cycle corner cases. A queue
// scoreboard checks every delivered result word.
module tb_adc_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  cfg_samp_len = 8'd0;
    logic [4:0]  cfg_ncomp = 5'd0;
    logic        cfg_cont = 1'b0;
    logic        comp_out = 1'b0;
    logic        seq_init, seq_samp, seq_comp, seq_update, busy;
    logic [15:0] result;
    logic        result_valid;
    logic        result_ready = 1'b1;
    logic        overrun;

    adc_seq #(.MAX_BITS(16), .SAMP_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cfg_samp_len (cfg_samp_len),
        .cfg_ncomp    (cfg_ncomp),
        .cfg_cont     (cfg_cont),
        .comp_out     (comp_out),
        .seq_init     (seq_init),
        .seq_samp     (seq_samp),
        .seq_comp     (seq_comp),
        .seq_update   (seq_update),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_init = 0, n_samp = 0, n_comp = 0, n_upd = 0, n_multi = 0;
    int n_busy = 0, n_valid = 0, n_ovr = 0;
    int dec_idx = 0;
    logic [15:0] dec_msb = 16'h0;   // decision k is dec_msb[15-k]
    logic [15:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Comparator model: one decision per COMP cycle, toggling noise otherwise
    always @(negedge clk) begin
        if (seq_init) dec_idx = 0;
        if (seq_comp) begin
            if (dec_idx < 16) comp_out = dec_msb[15 - dec_idx];
            dec_idx++;
        end else begin
            comp_out = ~comp_out;
        end
    end

    // Strobe/flag counters and scoreboard pop on handshake
    always @(negedge clk) begin
        if (seq_init)   n_init++;
        if (seq_samp)   n_samp++;
        if (seq_comp)   n_comp++;
        if (seq_update) n_upd++;
        if ((int'(seq_init) + int'(seq_samp) + int'(seq_comp) + int'(seq_update)) > 1) n_multi++;
        if (busy)         n_busy++;
        if (result_valid) n_valid++;
        if (overrun)      n_ovr++;
        if (result_valid && result_ready) begin
            if (exp_q.size() != 0) check("sb_word", 32'(result), 32'(exp_q.pop_front()));
            else check("sb_underflow", 32'(exp_q.size()), 1);
        end
    end

    typedef struct {
        string       name;
        logic [7:0]  s;
        logic [4:0]  n;
        logic [15:0] dec;
        logic [15:0] exp_word;
        int          exp_samp;
        int          exp_n;
        int          exp_lat;
    } vec_t;

    vec_t vecs[7];

    task automatic run_vec(input vec_t v);
        int b_init, b_samp, b_comp, b_upd, b_multi, b_busy, b_valid, t0;
        logic to;
        cfg_samp_len = v.s;
        cfg_ncomp    = v.n;
        dec_msb      = v.dec;
        @(negedge clk);
        b_init = n_init; b_samp = n_samp; b_comp = n_comp; b_upd = n_upd;
        b_multi = n_multi; b_busy = n_busy; b_valid = n_valid;
        start = 1'b1;
        t0 = cyc;
        exp_q.push_back(v.exp_word);
        @(negedge clk);
        start = 1'b0;
        to = 1'b1;
        for (int k = 0; k < 600; k++) begin
            if (result_valid) begin
                to = 1'b0;
                break;
            end
            @(negedge clk);
        end
        check({v.name, "_timeout"}, 32'(to), 0);
        check({v.name, "_latency"}, 32'(cyc - t0), 32'(v.exp_lat));
        repeat (2) @(negedge clk);
        check({v.name, "_init_cnt"},  32'(n_init - b_init), 1);
        check({v.name, "_samp_cnt"},  32'(n_samp - b_samp), 32'(v.exp_samp));
        check({v.name, "_comp_cnt"},  32'(n_comp - b_comp), 32'(v.exp_n));
        check({v.name, "_upd_cnt"},   32'(n_upd - b_upd), 32'(v.exp_n));
        check({v.name, "_multi"},     32'(n_multi - b_multi), 0);
        check({v.name, "_busy_cnt"},  32'(n_busy - b_busy), 32'(v.exp_lat - 1));
        check({v.name, "_valid_cnt"}, 32'(n_valid - b_valid), 1);
        check({v.name, "_result"},    32'(result), 32'(v.exp_word));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int b_init, b_valid, b_ovr, seen, tcyc[3];
        logic to, anyout;

        // name, S, N, decisions, expected word, samp cycles, comparisons, latency
        vecs[0] = '{"basic",   8'd4,   5'd16, 16'hB555, 16'hB555, 4,   16, 38};
        vecs[1] = '{"n4_ones", 8'd1,   5'd4,  16'hFFFF, 16'h000F, 1,   4,  11};
        vecs[2] = '{"clamp0",  8'd0,   5'd0,  16'h6C3A, 16'h6C3A, 1,   16, 35};
        vecs[3] = '{"n20",     8'd3,   5'd20, 16'h1234, 16'h1234, 3,   16, 37};
        vecs[4] = '{"n1",      8'd2,   5'd1,  16'h8000, 16'h0001, 2,   1,  6};
        vecs[5] = '{"n8",      8'd7,   5'd8,  16'hA5FF, 16'h00A5, 7,   8,  25};
        vecs[6] = '{"s255",    8'd255, 5'd15, 16'hFFFE, 16'h7FFF, 255, 15, 287};

        // Reset for two cycles, then idle with no start
        repeat (2) @(negedge clk);
        check("reset_state", 32'({seq_init, seq_samp, seq_comp, seq_update, busy,
                                  result_valid, overrun, result}), 0);
        rst = 1'b0;
        anyout = 1'b0;
        repeat (20) begin
            @(negedge clk);
            anyout = anyout | (|{seq_init, seq_samp, seq_comp, seq_update, busy,
                                 result_valid, overrun, result});
        end
        check("idle_quiet", 32'(anyout), 0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Backpressure: the first word is held and the second is dropped with an overrun
        result_ready = 1'b0;
        cfg_samp_len = 8'd1; cfg_ncomp = 5'd4; dec_msb = 16'hA000;
        @(negedge clk);
        b_ovr = n_ovr; b_valid = n_valid;
        start = 1'b1;
        exp_q.push_back(16'h000A);
        @(negedge clk);
        start = 1'b0;
        to = 1'b1;
        for (int k = 0; k < 100; k++) begin
            if (result_valid) begin to = 1'b0; break; end
            @(negedge clk);
        end
        check("bp_first_timeout", 32'(to), 0);
        dec_msb = 16'h5000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        to = 1'b1;
        for (int k = 0; k < 100; k++) begin
            if (!busy) begin to = 1'b0; break; end
            @(negedge clk);
        end
        check("bp_second_timeout", 32'(to), 0);
        repeat (2) @(negedge clk);
        check("bp_overrun_cnt", 32'(n_ovr - b_ovr), 1);
        check("bp_result_held", 32'(result), 32'h000A);
        check("bp_valid_held", 32'(result_valid), 1);
        @(posedge clk);
        #2 result_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_valid_cleared", 32'(result_valid), 0);

        // Reset during the 5th COMP discards the partial word
        cfg_samp_len = 8'd4; cfg_ncomp = 5'd16; dec_msb = 16'hFFFF;
        @(negedge clk);
        b_init = n_init; b_valid = n_valid;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        for (int k = 0; k < 100 && seen < 5; k++) begin
            if (seq_comp) seen++;
            if (seen < 5) @(negedge clk);
        end
        check("rst_mid_reached", 32'(seen), 5);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_outputs", 32'({seq_init, seq_samp, seq_comp, seq_update, busy,
                                      result_valid, overrun, result}), 0);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        check("rst_mid_no_valid", 32'(n_valid - b_valid), 0);
        check("rst_mid_no_restart", 32'(n_init - b_init), 1);

        // start held through a whole conversion gives exactly one conversion
        cfg_samp_len = 8'd2; cfg_ncomp = 5'd4; dec_msb = 16'hC000;
        @(negedge clk);
        b_init = n_init; b_valid = n_valid;
        exp_q.push_back(16'h000C);
        start = 1'b1;
        repeat (12) @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        check("hold_init_cnt", 32'(n_init - b_init), 1);
        check("hold_valid_cnt", 32'(n_valid - b_valid), 1);

`ifdef ADC_SEQ_CONT_EN
        // Continuous mode: INIT every 1+S+2N cycles, then stop once cfg_cont drops
        cfg_samp_len = 8'd2; cfg_ncomp = 5'd8; dec_msb = 16'h3C00;
        cfg_cont = 1'b1;
        @(negedge clk);
        b_init = n_init; b_valid = n_valid;
        repeat (3) exp_q.push_back(16'h003C);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        tcyc[0] = 0; tcyc[1] = 0; tcyc[2] = 0;
        for (int k = 0; k < 200 && seen < 3; k++) begin
            if (seq_init) begin
                tcyc[seen] = cyc;
                seen++;
            end
            if (seen < 3) @(negedge clk);
        end
        cfg_cont = 1'b0;
        check("cont_inits_seen", 32'(seen), 3);
        check("cont_period_1", 32'(tcyc[1] - tcyc[0]), 19);
        check("cont_period_2", 32'(tcyc[2] - tcyc[1]), 19);
        to = 1'b1;
        for (int k = 0; k < 100; k++) begin
            if (!busy) begin to = 1'b0; break; end
            @(negedge clk);
        end
        check("cont_stop_timeout", 32'(to), 0);
        repeat (10) @(negedge clk);
        check("cont_init_cnt", 32'(n_init - b_init), 3);
        check("cont_valid_cnt", 32'(n_valid - b_valid), 3);
        check("cont_idle_busy", 32'(busy), 0);
`else
        // cfg_cont is ignored: a single conversion only
        cfg_samp_len = 8'd1; cfg_ncomp = 5'd2; dec_msb = 16'hC000;
        cfg_cont = 1'b1;
        @(negedge clk);
        b_init = n_init; b_valid = n_valid;
        exp_q.push_back(16'h0003);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        cfg_cont = 1'b0;
        check("nocont_init_cnt", 32'(n_init - b_init), 1);
        check("nocont_valid_cnt", 32'(n_valid - b_valid), 1);
`endif

        check("overrun_total", 32'(n_ovr), 1);
        check("sb_drained", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
